packet_length_meter: RTL and testbench

Passive AXI-Stream tap that measures the byte length of every packet crossing a monitored stream and flags bad packets. It emits one length record per packet on a `plen` side-channel that feeds the per-size `packet_counter` stage directly downstream. It never drives `tready` and never stalls the monitored stream.

---
 rtl/packet_length_meter.sv | 108 ++++++++++
 tb/tb_packet_length_meter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/packet_length_meter.sv
// rtl/packet_length_meter.sv - passive AXI-Stream tap emitting one byte-length record per packet
// Optional PLEN_OVERSIZE_EN: also flag packets longer than MAX_LEN bytes.
module packet_length_meter #(
    parameter int DW      = 512,
    parameter int MAX_LEN = 9600
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DW-1:0]    axis_tdata,
    input  logic [DW/8-1:0]  axis_tkeep,
    input  logic             axis_tlast,
    input  logic             axis_tuser,
    input  logic             axis_tvalid,
    input  logic             axis_tready,
    output logic [15:0]      plen_tdata,
    output logic             plen_tvalid,
    output logic             plen_tuser
);
    localparam int KW = DW / 8;
    localparam int CW = $clog2(KW + 1);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_IN_PKT = 1'b1;

    logic [CW-1:0] keep_bytes;
    logic          s1_valid;
    logic [CW-1:0] s1_bytes;
    logic          s1_last;
    logic          s1_user;

    logic [0:0]    state;
    logic [16:0]   acc;
    logic          sat;
    logic          err;

    logic          in_pkt;
    logic [16:0]   sum;
    logic [16:0]   next_acc;
    logic          next_sat;
    logic          next_err;
    logic          bad;

    // tkeep may be sparse, so every set bit is one byte
    always_comb begin
        keep_bytes = '0;
        for (int i = 0; i < KW; i++) begin
            keep_bytes = keep_bytes + CW'(axis_tkeep[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_bytes <= '0;
            s1_last  <= 1'b0;
            s1_user  <= 1'b0;
        end else begin
            s1_valid <= axis_tvalid & axis_tready;
            if (axis_tvalid && axis_tready) begin
                s1_bytes <= keep_bytes;
                s1_last  <= axis_tlast;
                s1_user  <= axis_tuser;
            end
        end
    end

    // A beat in IDLE starts from zero, which lets a tlast beat and the next
    // packet's first beat run back to back without a bubble.
    always_comb begin
        in_pkt   = (state == ST_IN_PKT);
        sum      = (in_pkt ? acc : 17'd0) + 17'(s1_bytes);
        next_sat = (in_pkt & sat) | (sum > 17'h0FFFF);
        next_acc = (sum > 17'h0FFFF) ? 17'h0FFFF : sum;
        next_err = (in_pkt & err) | s1_user;
`ifdef PLEN_OVERSIZE_EN
        bad      = next_err | next_sat | (next_acc > 17'(MAX_LEN));
`else
        bad      = next_err | next_sat;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            acc         <= '0;
            sat         <= 1'b0;
            err         <= 1'b0;
            plen_tvalid <= 1'b0;
            plen_tdata  <= '0;
            plen_tuser  <= 1'b0;
        end else begin
            plen_tvalid <= 1'b0;
            if (s1_valid) begin
                acc <= next_acc;
                sat <= next_sat;
                err <= next_err;
                if (s1_last) begin
                    state       <= ST_IDLE;
                    plen_tvalid <= 1'b1;
                    plen_tdata  <= next_acc[15:0];
                    plen_tuser  <= bad;
                end else begin
                    state <= ST_IN_PKT;
                end
            end
        end
    end
endmodule

// File: tb/tb_packet_length_meter.sv
// tb/tb_packet_length_meter.sv - self-checking bench for packet_length_meter
module tb_packet_length_meter;
    localparam int DW      = 512;
    localparam int KW      = DW / 8;
    localparam int MAX_LEN = 9600;

    logic            clk = 1'b0;
    logic            reset;
    logic [DW-1:0]   axis_tdata;
    logic [KW-1:0]   axis_tkeep;
    logic            axis_tlast;
    logic            axis_tuser;
    logic            axis_tvalid;
    logic            axis_tready;
    logic [15:0]     plen_tdata;
    logic            plen_tvalid;
    logic            plen_tuser;

    packet_length_meter #(.DW(DW), .MAX_LEN(MAX_LEN)) dut (
        .clk         (clk),
        .reset       (reset),
        .axis_tdata  (axis_tdata),
        .axis_tkeep  (axis_tkeep),
        .axis_tlast  (axis_tlast),
        .axis_tuser  (axis_tuser),
        .axis_tvalid (axis_tvalid),
        .axis_tready (axis_tready),
        .plen_tdata  (plen_tdata),
        .plen_tvalid (plen_tvalid),
        .plen_tuser  (plen_tuser)
    );

    always #5 clk = ~clk;

    typedef struct {
        int data;
        bit user;
        int due;
    } rec_t;

    rec_t q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    int   m_sum  = 0;
    bit   m_err  = 1'b0;
    int   hold_d = 0;
    bit   hold_u = 1'b0;

    localparam logic [KW-1:0] FULL = '1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock: drive, let the edge take it, update the model, check at negedge.
    task automatic tick(input bit v, input bit r, input logic [KW-1:0] k,
                        input bit l, input bit u, input bit rst);
        rec_t rec;
        bit   exp_v;
        bit   big;
        reset       = rst;
        axis_tvalid = v;
        axis_tready = r;
        axis_tkeep  = k;
        axis_tlast  = l;
        axis_tuser  = u;
        axis_tdata  = {16{$urandom()}};
        if (rst) begin
            q.delete();
            m_sum  = 0;
            m_err  = 1'b0;
            hold_d = 0;
            hold_u = 1'b0;
        end else if (v && r) begin
            m_sum += $countones(k);
            m_err |= u;
            if (l) begin
                big      = (m_sum > 65535);
                rec.data = big ? 65535 : m_sum;
                rec.user = m_err | big;
`ifdef PLEN_OVERSIZE_EN
                if (m_sum > MAX_LEN) rec.user = 1'b1;
`endif
                rec.due  = cyc + 2;
                q.push_back(rec);
                m_sum = 0;
                m_err = 1'b0;
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        exp_v = (q.size() > 0) && (q[0].due == cyc);
        if (exp_v) begin
            hold_d = q[0].data;
            hold_u = q[0].user;
            void'(q.pop_front());
        end
        check("plen_tvalid", 32'(plen_tvalid), 32'(exp_v));
        check("plen_tdata",  32'(plen_tdata),  32'(hold_d));
        check("plen_tuser",  32'(plen_tuser),  32'(hold_u));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b1, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic full_run(input int n_full, input logic [KW-1:0] last_keep);
        for (int i = 0; i < n_full; i++) tick(1'b1, 1'b1, FULL, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b1, last_keep, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        logic [KW-1:0] k;
        tick(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        idle(2);

        // 4 x 64 bytes -> 256
        full_run(3, FULL);
        idle(3);

        // 64 + 4 + 0 -> 68
        tick(1'b1, 1'b1, FULL, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 64'h0F, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b1, '0, 1'b1, 1'b0, 1'b0);
        idle(3);

        // sparse keep with tready throttled on alternate cycles
        tick(1'b1, 1'b0, FULL, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b1, FULL, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 64'h55, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 64'h55, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b1, '0, 1'b1, 1'b0, 1'b0);
        idle(3);

        // back-to-back single-beat packets
        tick(1'b1, 1'b1, 64'h1, 1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 64'h3, 1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b1, 64'h7, 1'b1, 1'b0, 1'b0);
        idle(3);

        // saturation: 1100 full beats
        full_run(1099, FULL);
        idle(3);

        // oversize boundary: 9600 and 9601 bytes
        full_run(149, FULL);
        full_run(150, 64'h1);
        idle(3);

        // reset mid-packet drops the partial sum
        tick(1'b1, 1'b1, FULL, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b1, FULL, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        tick(1'b1, 1'b1, 64'h0000_00FF_FFFF_FFFF, 1'b1, 1'b0, 1'b0);
        idle(3);

        // randomized traffic against the packet-level model
        for (int i = 0; i < 400; i++) begin
            k = {$urandom(), $urandom()};
            if ($urandom_range(0, 3) == 0) k = FULL;
            if ($urandom_range(0, 7) == 0) k = '0;
            tick($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, k,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0, 1'b0);
        end
        tick(1'b1, 1'b1, FULL, 1'b1, 1'b0, 1'b0);
        idle(4);

        check("queue_drained", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
